// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_pkg : shared types and constants for the segment scanner |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low a..g patterns, entry n holds the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_ctrl_if : data load and display pins of the scanner      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [7:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_sync;
    logic                      pending;

    modport master (
        output enable, load, data_in, dp_in,
        input  seg, an, frame_sync, pending
    );

    modport slave (
        input  enable, load, data_in, dp_in,
        output seg, an, frame_sync, pending
    );
endinterface
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_hex_decode : hex nibble to active-low a..g segment pattern    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  wire logic [3:0] nibble,
    output      logic [6:0] seg
);
    assign seg = HEX_SEG_TABLE[nibble];
endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_scan_ctrl : multiplexed common-anode display scanner with     |
// | guard interval and frame-aligned double buffering.                |
// | Optional SEG_SCAN_LZB_EN adds leading-zero blanking.              |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 500
) (
    input wire logic        clk,
    input wire logic        rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic w_enter_frame;
    logic w_transfer;

    logic [NUM_DIGITS-1:0][3:0] r_pend_data, r_disp_data;
    logic [NUM_DIGITS-1:0]      r_pend_dp,   r_disp_dp;
    logic                       r_pending;
    logic [7:0]                 r_seg;
    logic [NUM_DIGITS-1:0]      r_an;
    logic                       r_frame_sync;
    logic [6:0]                 w_dec_seg;
    logic [6:0]                 w_digit_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_enter_frame = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt   = ST_GUARD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_enter_frame = 1'b1;
                end
                ST_GUARD: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == C_GUARD_LAST) w_state_nxt = ST_SHOW;
                end
                ST_SHOW: begin
                    if (r_cnt == C_SLOT_LAST) begin
                        w_state_nxt = ST_GUARD;
                        w_cnt_nxt   = '0;
                        if (r_idx == C_IDX_LAST) begin
                            w_idx_nxt     = '0;
                            w_enter_frame = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_transfer = r_pending && ((r_state == ST_OFF) || w_enter_frame);

    // A load coinciding with a transfer moves the old pending data and re-arms pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_disp_data <= r_pend_data;
                r_disp_dp   <= r_pend_dp;
            end
            if (bus.load) begin
                r_pend_data <= bus.data_in;
                r_pend_dp   <= bus.dp_in;
                r_pending   <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (r_disp_data[r_idx]),
        .seg    (w_dec_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] r_blank;

    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input logic [NUM_DIGITS-1:0][3:0] digits
    );
        logic run;
        run            = 1'b1;
        lead_zero_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run               = run && (digits[i] == 4'h0);
            lead_zero_mask[i] = run;
        end
    endfunction

    // Reset value matches the all-zero display buffer: every digit but 0 blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= ~NUM_DIGITS'(1);
        end else if (w_transfer) begin
            r_blank <= lead_zero_mask(r_pend_data);
        end
    end

    assign w_digit_seg = r_blank[r_idx] ? 7'h7F : w_dec_seg;
`else
    assign w_digit_seg = w_dec_seg;
`endif

    // Outputs follow the state one cycle late; dropping enable darkens them at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= SEG_BLANK;
            r_an         <= '1;
            r_frame_sync <= 1'b0;
        end else begin
            r_frame_sync <= bus.enable && (r_state == ST_GUARD) &&
                            (r_idx == '0) && (r_cnt == '0);
            if (bus.enable && (r_state == ST_SHOW)) begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= {~r_disp_dp[r_idx], w_digit_seg};
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_sync = r_frame_sync;
    assign bus.pending    = r_pending;

endmodule
`default_nettype wire
